// File: rtl/tournament_branch_predictor_pkg.sv
// bp_pkg: shared types and helpers for the tournament branch predictor.
//   ctr2_t      - 2-bit saturating counter held in every table entry
//   SNT..ST     - counter encodings (strongly/weakly not-taken/taken)
//   BP_*        - values of the predictor MODE parameter
//   sat_step()  - one saturating step of a counter toward a direction
package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'b00;
  localparam ctr2_t WNT = 2'b01;
  localparam ctr2_t WT  = 2'b10;
  localparam ctr2_t ST  = 2'b11;

  localparam int BP_STATIC     = 0;
  localparam int BP_BIMODAL    = 1;
  localparam int BP_GSHARE     = 2;
  localparam int BP_TOURNAMENT = 3;

  // Move a counter one step toward 'up' (1 = toward ST), clamping at both ends.
  function automatic ctr2_t sat_step(ctr2_t c, logic up);
    ctr2_t r;
    if (up) begin
      r = (c == ST) ? ST : c + 2'd1;
    end else begin
      r = (c == SNT) ? SNT : c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tournament_branch_predictor_if.sv
// tournament_branch_predictor_if: pipeline-side bundle of the predictor.
//   Pipeline -> predictor: pcF, stall/flush for D/E/M, branchD, branchE,
//     actual_takeE, branchM, pcM, actual_takeM.
//   Predictor -> pipeline: predictF, predictD, predictE, mispredictE,
//     stat_branch_cnt, stat_miss_cnt.
// The master modport is the pipeline, the slave modport is the predictor.
interface tournament_branch_predictor_if;

  logic [31:0] pcF;
  logic        stallD;
  logic        flushD;
  logic        stallE;
  logic        flushE;
  logic        stallM;
  logic        flushM;
  logic        branchD;
  logic        branchE;
  logic        actual_takeE;
  logic        branchM;
  logic [31:0] pcM;
  logic        actual_takeM;

  logic        predictF;
  logic        predictD;
  logic        predictE;
  logic        mispredictE;
  logic [31:0] stat_branch_cnt;
  logic [31:0] stat_miss_cnt;

  modport master (
    output pcF, stallD, flushD, stallE, flushE, stallM, flushM,
           branchD, branchE, actual_takeE, branchM, pcM, actual_takeM,
    input  predictF, predictD, predictE, mispredictE,
           stat_branch_cnt, stat_miss_cnt
  );

  modport slave (
    input  pcF, stallD, flushD, stallE, flushE, stallM, flushM,
           branchD, branchE, actual_takeE, branchM, pcM, actual_takeM,
    output predictF, predictD, predictE, mispredictE,
           stat_branch_cnt, stat_miss_cnt
  );

endinterface

// File: rtl/tournament_branch_predictor_pht.sv
// bp_pht: table of 2^IDX_W two-bit saturating counters.
//   clk, rst        - clock and async active-high reset (all entries -> WNT)
//   rdIdx / rdCtr   - combinational read port (reads state before any write
//                     landing on the same edge)
//   wrIdx, wrDir,
//   wrEn            - one saturating step of entry wrIdx toward wrDir
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdx,
  output ctr2_t            rdCtr,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrDir,
  input  logic             wrEn
);

  localparam int DEPTH = 1 << IDX_W;

  ctr2_t entries [DEPTH];

  assign rdCtr = entries[rdIdx];

  // Counters start weakly not-taken so a cold entry flips after one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= WNT;
      end
    end else if (wrEn) begin
      entries[wrIdx] <= sat_step(entries[wrIdx], wrDir);
    end
  end

endmodule

// File: rtl/tournament_branch_predictor.sv
// tournament_branch_predictor: static/bimodal/gshare/tournament direction
// predictor that sits beside the 5-stage pipeline.
//   clk, rst - clock and async active-high reset
//   bp       - slave side of tournament_branch_predictor_if: Fetch PC in,
//              predictF/predictD/predictE/mispredictE out, pipeline
//              stall/flush controls, E-stage resolution for history repair,
//              M-stage retirement for table training and the two 32-bit
//              statistics counters.
// Each Fetch lookup is captured as a record (component bits, final
// prediction, history used) that travels D -> E -> M alongside the
// instruction, so repair and training use exactly what the lookup saw.
module tournament_branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int GHR_W = 8,
  parameter int MODE  = 3
) (
  input logic                         clk,
  input logic                         rst,
  tournament_branch_predictor_if.slave bp
);

  typedef struct packed {
    logic             valid;
    logic             bim;
    logic             gs;
    logic             pred;
    logic [GHR_W-1:0] snap;
  } rec_t;

  logic [GHR_W-1:0] ghr;
  rec_t             lookupF;
  rec_t             recD;
  rec_t             recE;
  rec_t             recM;

  logic [IDX_W-1:0] biIdxF;
  logic [IDX_W-1:0] gsIdxF;
  logic [IDX_W-1:0] biIdxM;
  logic [IDX_W-1:0] gsIdxM;
  ctr2_t            bimRd;
  ctr2_t            gsRd;
  ctr2_t            chRd;
  logic             predF;
  logic             mispredE;
  logic             trainM;
  logic             chtEn;
  logic             gsCorrectM;
  logic [31:0]      branchCnt;
  logic [31:0]      missCnt;
  logic             unusedBits;

  assign biIdxF = bp.pcF[IDX_W+1:2];
  assign gsIdxF = biIdxF ^ IDX_W'(ghr);
  assign biIdxM = bp.pcM[IDX_W+1:2];
  assign gsIdxM = biIdxM ^ IDX_W'(recM.snap);

  assign trainM     = bp.branchM & ~bp.stallM & recM.valid;
  assign gsCorrectM = (recM.gs == bp.actual_takeM);
  assign chtEn      = trainM & (recM.bim != recM.gs);

  // All three tables always train, whatever MODE selects for prediction.
  bp_pht #(.IDX_W(IDX_W)) bhtTable (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (biIdxF),
    .rdCtr (bimRd),
    .wrIdx (biIdxM),
    .wrDir (bp.actual_takeM),
    .wrEn  (trainM)
  );

  bp_pht #(.IDX_W(IDX_W)) gphtTable (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (gsIdxF),
    .rdCtr (gsRd),
    .wrIdx (gsIdxM),
    .wrDir (bp.actual_takeM),
    .wrEn  (trainM)
  );

  // Chooser moves toward gshare (11) only when the components disagreed.
  bp_pht #(.IDX_W(IDX_W)) chtTable (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (biIdxF),
    .rdCtr (chRd),
    .wrIdx (biIdxM),
    .wrDir (gsCorrectM),
    .wrEn  (chtEn)
  );

  always_comb begin
    predF = 1'b0;
    case (MODE)
      BP_BIMODAL:    predF = bimRd[1];
      BP_GSHARE:     predF = gsRd[1];
      BP_TOURNAMENT: predF = chRd[1] ? gsRd[1] : bimRd[1];
      default:       predF = 1'b0;
    endcase
  end

  assign lookupF = '{valid: 1'b1, bim: bimRd[1], gs: gsRd[1], pred: predF, snap: ghr};

  // Lookup records follow the pipeline registers; flush beats stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recD <= '0;
      recE <= '0;
      recM <= '0;
    end else begin
      if (bp.flushD) begin
        recD <= '0;
      end else if (!bp.stallD) begin
        recD <= lookupF;
      end
      if (bp.flushE) begin
        recE <= '0;
      end else if (!bp.stallE) begin
        recE <= recD;
      end
      if (bp.flushM) begin
        recM <= '0;
      end else if (!bp.stallM) begin
        recM <= recE;
      end
    end
  end

  assign mispredE = bp.branchE & (recE.pred != bp.actual_takeE);

  // Repair rebuilds history from the E branch's snapshot and real outcome,
  // discarding any younger speculative shift from the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (mispredE && !bp.stallE) begin
      ghr <= (recE.snap << 1) | GHR_W'(bp.actual_takeE);
    end else if (bp.branchD && !bp.stallD) begin
      ghr <= (ghr << 1) | GHR_W'(recD.pred);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchCnt <= '0;
      missCnt   <= '0;
    end else if (trainM) begin
      branchCnt <= branchCnt + 32'd1;
      if (recM.pred != bp.actual_takeM) begin
        missCnt <= missCnt + 32'd1;
      end
    end
  end

  assign bp.predictF        = predF;
  assign bp.predictD        = recD.pred;
  assign bp.predictE        = recE.pred;
  assign bp.mispredictE     = mispredE;
  assign bp.stat_branch_cnt = branchCnt;
  assign bp.stat_miss_cnt   = missCnt;

  // PC bits outside the index field and the counters' low bits are unused.
  assign unusedBits = ^{bp.pcF[31:IDX_W+2], bp.pcF[1:0],
                        bp.pcM[31:IDX_W+2], bp.pcM[1:0],
                        bimRd[0], gsRd[0], chRd[0]};

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed bench for tournament_branch_predictor. Two instances share one
// stimulus: dutT (MODE=3, GHR_W=4) and dutB (MODE=1, GHR_W=4).
module tb_tournament_branch_predictor;
  import bp_pkg::*;

  localparam logic [31:0] PC0 = 32'h0040_0000;
  localparam logic [31:0] PCB = 32'h0040_0010;
  localparam logic [31:0] PCL = 32'h0040_0020;
  localparam logic [31:0] PCC = 32'h0040_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF, pcM;
  logic        stallD, flushD, stallE, flushE, stallM, flushM;
  logic        branchD, branchE, actual_takeE, branchM, actual_takeM;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tournament_branch_predictor_if busT ();
  tournament_branch_predictor_if busB ();

  assign {busT.pcF, busT.stallD, busT.flushD, busT.stallE, busT.flushE,
          busT.stallM, busT.flushM, busT.branchD, busT.branchE,
          busT.actual_takeE, busT.branchM, busT.pcM, busT.actual_takeM} =
         {pcF, stallD, flushD, stallE, flushE, stallM, flushM, branchD,
          branchE, actual_takeE, branchM, pcM, actual_takeM};

  assign {busB.pcF, busB.stallD, busB.flushD, busB.stallE, busB.flushE,
          busB.stallM, busB.flushM, busB.branchD, busB.branchE,
          busB.actual_takeE, busB.branchM, busB.pcM, busB.actual_takeM} =
         {pcF, stallD, flushD, stallE, flushE, stallM, flushM, branchD,
          branchE, actual_takeE, branchM, pcM, actual_takeM};

  tournament_branch_predictor #(.IDX_W(10), .GHR_W(4), .MODE(3)) dutT (
    .clk (clk),
    .rst (rst),
    .bp  (busT.slave)
  );

  tournament_branch_predictor #(.IDX_W(10), .GHR_W(4), .MODE(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bp  (busB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges; return 2 time units after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Retire one branch at pcM for a single edge, then let a fresh lookup
  // propagate all the way to M before the next retirement.
  task automatic applyStimulus(input logic taken);
    branchM = 1'b1;
    actual_takeM = taken;
    step(1);
    branchM = 1'b0;
    step(3);
  endtask

  initial begin
    rst = 1'b1;
    pcF = PC0; pcM = PC0;
    {stallD, flushD, stallE, flushE, stallM, flushM} = '0;
    {branchD, branchE, actual_takeE, branchM, actual_takeM} = '0;

    // Reset state
    step(2);
    checkOutput("rst predictD", 32'(busT.predictD), 32'd0);
    checkOutput("rst predictE", 32'(busT.predictE), 32'd0);
    checkOutput("rst mispredictE", 32'(busT.mispredictE), 32'd0);
    checkOutput("rst branch cnt", busT.stat_branch_cnt, 32'd0);
    checkOutput("rst cold predictF", 32'(busT.predictF), 32'd0);
    rst = 1'b0;

    // Bimodal walk on dutB at PCB (index 4)
    pcF = PCB; pcM = PCB;
    step(4);
    checkOutput("bim cold predictF", 32'(busB.predictF), 32'd0);
    applyStimulus(1'b1);
    checkOutput("bim T1 entry", 32'(dutB.bhtTable.entries[4]), 32'(WT));
    checkOutput("bim T1 predictF", 32'(busB.predictF), 32'd1);
    applyStimulus(1'b1);
    checkOutput("bim T2 entry", 32'(dutB.bhtTable.entries[4]), 32'(ST));
    applyStimulus(1'b1);
    checkOutput("bim T3 entry", 32'(dutB.bhtTable.entries[4]), 32'(ST));
    applyStimulus(1'b0);
    checkOutput("bim N1 predictF", 32'(busB.predictF), 32'd1);
    applyStimulus(1'b0);
    checkOutput("bim N2 predictF", 32'(busB.predictF), 32'd0);
    checkOutput("bim branch cnt", busB.stat_branch_cnt, 32'd5);
    checkOutput("bim miss cnt", busB.stat_miss_cnt, 32'd3);
    checkOutput("tour miss cnt", busT.stat_miss_cnt, 32'd3);

    // Stall / flush on D
    applyStimulus(1'b1);
    checkOutput("predictD before stall", 32'(busB.predictD), 32'd1);
    stallD = 1'b1; pcF = PC0;
    step(1);
    checkOutput("predictD held by stall", 32'(busB.predictD), 32'd1);
    stallD = 1'b0;
    step(1);
    checkOutput("predictD after stall", 32'(busB.predictD), 32'd0);
    pcF = PCB;
    step(1);
    checkOutput("predictD reload", 32'(busB.predictD), 32'd1);
    flushD = 1'b1;
    step(1);
    checkOutput("predictD flushed", 32'(busB.predictD), 32'd0);
    flushD = 1'b0;

    // flushM leaves the branch in M untrained and uncounted
    step(4);
    flushM = 1'b1;
    step(1);
    flushM = 1'b0; branchM = 1'b1; pcM = PCB; actual_takeM = 1'b1;
    step(1);
    branchM = 1'b0;
    checkOutput("flushM branch cnt", busB.stat_branch_cnt, 32'd6);
    checkOutput("flushM entry", 32'(dutB.bhtTable.entries[4]), 32'(WT));
    checkOutput("flushM miss cnt", busB.stat_miss_cnt, 32'd4);

    // 20 retirements, pattern N N N T, at a cold entry: 5 mispredicts
    pcF = PCL; pcM = PCL;
    step(4);
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 4) == 3);
    end
    checkOutput("loop branch cnt B", busB.stat_branch_cnt, 32'd26);
    checkOutput("loop miss cnt B", busB.stat_miss_cnt, 32'd9);
    checkOutput("loop miss cnt T", busT.stat_miss_cnt, 32'd9);

    // Chooser, phase 1: history 0, components agree
    pcF = PCC; pcM = PCC;
    step(4);
    applyStimulus(1'b1);
    checkOutput("cht agree 1", 32'(dutT.chtTable.entries[16]), 32'(WNT));
    applyStimulus(1'b1);
    checkOutput("cht agree 2", 32'(dutT.chtTable.entries[16]), 32'(WNT));

    // GHR speculation then repair winning over a same-cycle shift
    branchD = 1'b1;
    step(1);
    checkOutput("ghr speculative", 32'(dutT.ghr), 32'h1);
    branchE = 1'b1; actual_takeE = 1'b0;
    #1;
    checkOutput("mispredictE", 32'(busT.mispredictE), 32'd1);
    step(1);
    checkOutput("ghr repaired", 32'(dutT.ghr), 32'h0);
    branchE = 1'b0;
    step(1);
    checkOutput("ghr respeculated", 32'(dutT.ghr), 32'h1);
    branchD = 1'b0;

    // Chooser, phase 2: history 0001, bimodal says T, gshare says N
    step(4);
    applyStimulus(1'b0);
    checkOutput("cht disagree 1", 32'(dutT.chtTable.entries[16]), 32'(WT));
    checkOutput("tour predictF gshare", 32'(busT.predictF), 32'd0);
    applyStimulus(1'b0);
    checkOutput("cht disagree 2", 32'(dutT.chtTable.entries[16]), 32'(ST));
    applyStimulus(1'b0);
    checkOutput("cht agree 3", 32'(dutT.chtTable.entries[16]), 32'(ST));
    checkOutput("tour branch cnt", busT.stat_branch_cnt, 32'd31);
    checkOutput("tour miss cnt end", busT.stat_miss_cnt, 32'd11);
    checkOutput("bim miss cnt end", busB.stat_miss_cnt, 32'd12);

    // Reset mid-run
    pcF = PC0;
    rst = 1'b1;
    #1;
    checkOutput("mid rst predictF", 32'(busT.predictF), 32'd0);
    checkOutput("mid rst predictD", 32'(busT.predictD), 32'd0);
    checkOutput("mid rst predictE", 32'(busT.predictE), 32'd0);
    checkOutput("mid rst branch cnt", busT.stat_branch_cnt, 32'd0);
    checkOutput("mid rst miss cnt", busT.stat_miss_cnt, 32'd0);
    checkOutput("mid rst ghr", 32'(dutT.ghr), 32'd0);
    checkOutput("mid rst bht entry", 32'(dutB.bhtTable.entries[4]), 32'(WNT));
    step(1);
    rst = 1'b0;

    // Counter wrap
    force dutT.branchCnt = 32'hFFFF_FFFF;
    #1;
    release dutT.branchCnt;
    #1;
    checkOutput("wrap preload", busT.stat_branch_cnt, 32'hFFFF_FFFF);
    pcF = PCB; pcM = PCB;
    step(4);
    applyStimulus(1'b1);
    checkOutput("wrap branch cnt", busT.stat_branch_cnt, 32'h0000_0000);
    checkOutput("wrap miss cnt", busT.stat_miss_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tournament_branch_predictor.md
# tournament_branch_predictor

Parametrised successor to the core's fixed dynamic branch predictor: a selectable static/bimodal/gshare/tournament direction predictor with global history, speculative history update at Decode, history repair on an Execute-stage mispredict, and table training at Memory. It sits beside the 5-stage pipeline. It delivers `predictF`/`predictD` to the Fetch PC mux and tracks its own history snapshots down to M. Two 32-bit performance counters are included.

## Interface
- `IDX_W`, default 10: PHT index width; each table holds 2^IDX_W entries.
- `GHR_W`, default 8: global history length; must satisfy 1 ≤ GHR_W ≤ IDX_W.
- `MODE`, default 3: prediction mode.
  - 0: static not-taken.
  - 1: bimodal.
  - 2: gshare.
  - 3: tournament.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pcF` in 32: Fetch PC.
- `stallD`, `flushD`, `stallE`, `flushE`, `stallM`, `flushM` in 1 each: pipeline register controls, same meaning as the core's hazard unit.
- `branchD` in 1: the D instruction is a conditional branch.
- `branchE` in 1: the E instruction is a conditional branch.
- `actual_takeE` in 1: resolved direction in E.
- `branchM` in 1: branch present in M.
- `pcM` in 32: PC of the M instruction.
- `actual_takeM` in 1: resolved direction in M.
- `predictF` out 1: combinational prediction for `pcF`.
- `predictD` out 1: registered prediction for the D instruction.
- `predictE` out 1: prediction carried to E.
- `mispredictE` out 1: `branchE & (predictE != actual_takeE)`.
- `stat_branch_cnt` out 32: number of branches retired through M.
- `stat_miss_cnt` out 32: number of those branches that were mispredicted.

## Operation
- **Tables:**
  - BHT (bimodal), GPHT (gshare), and CHT (chooser).
  - Each entry is a 2-bit saturating counter. Bit 1 = taken for BHT/GPHT; bit 1 = choose gshare for CHT.
  - Reset value of every entry: 2'b01.
- **Indexing:**
  - `bi_idx = pc[IDX_W+1:2]`.
  - `gs_idx = pc[IDX_W+1:2] ^ {zero-pad, GHR}`.
  - The chooser uses `bi_idx`.
- **predictF by MODE:**
  - 0 → 0.
  - 1 → BHT[bi_idx][1].
  - 2 → GPHT[gs_idx][1].
  - 3 → CHT[1] ? GPHT bit : BHT bit.
- **Lookup record:** each lookup records {bimodal bit, gshare bit, GHR value used} with the instruction. The record is carried F→D→E→M in internal registers gated and cleared by the matching stall/flush pair. A flush clears the record's valid bit.
- **GHR:**
  - Speculative: on `branchD & ~stallD`, `GHR <= {GHR[GHR_W-2:0], predictD}`.
  - Repair: on `mispredictE & ~stallE`, `GHR <= {snapE[GHR_W-2:0], actual_takeE}`, where `snapE` is the pre-shift history recorded for the E branch.
  - When repair and a speculative shift occur in the same cycle, repair wins.
- **Training:** on `branchM & ~stallM & validM`:
  - BHT[pcM idx] and GPHT[snapM-derived idx] step toward `actual_takeM`, saturating at 00 and 11.
  - CHT steps only when the two recorded component predictions differ: toward 11 if gshare was correct, toward 00 otherwise.
  - MODE 0/1/2 still train all tables, so switching MODE between builds needs no other changes.
- **Counters:**
  - `stat_branch_cnt` increments on each training event.
  - `stat_miss_cnt` increments when the recorded final prediction ≠ `actual_takeM`.
  - Both wrap modulo 2^32.

## Timing
- `predictF` has zero latency from `pcF` and reads current table state.
- A same-cycle M write to the indexed entry is not visible to `predictF` until the next cycle.
- `predictD` is updated at the edge with `~stallD`: `flushD ? 0 : predictF`. It holds while `stallD` is asserted.
- E and M records follow the same rule with their own stall/flush pair. Flush has priority over stall.
- GHR and table updates are single-edge.
- **Reset (async, immediate):**
  - All table entries = 01.
  - GHR = 0.
  - `predictD` = `predictE` = 0 and all record valids = 0.
  - `mispredictE` = 0.
  - Both stat counters = 0.
- Reset deasserted mid-operation leaves all state at reset values. The first valid lookup follows on the next edge.

## Structure
- **Package `bp_pkg`:**
  - `ctr2_t` (2-bit counter type).
  - Constants SNT=00, WNT=01, WT=10, ST=11.
  - MODE encodings BP_STATIC/BP_BIMODAL/BP_GSHARE/BP_TOURNAMENT.
  - Function `sat_step(ctr2_t c, logic up)`.
- **Sub-module `bp_pht`:** parametrised on IDX_W, with one combinational read port, one write port (index, direction, enable), and async reset to WNT. It is instantiated three times (BHT, GPHT, CHT). The top holds the GHR, records, and counters.

## Test plan
- **Reset and cold lookup:** assert `rst` mid-run with MODE=3. Required: all outputs 0; then `pcF`=0x00400000 → `predictF`=0 (WNT).
- **Bimodal saturation (MODE=1):** retire a branch at `pcM`=0x00400010 taken 3×. Required: entry walks 01→10→11→11 and `predictF` for that PC =1 from the edge after the first retirement. Then 2 not-taken retirements → `predictF`=0.
- **GHR speculation and repair (GHR_W=4, GHR=0):**
  - `branchD` with `predictD`=1 → GHR=0001.
  - Next cycle `mispredictE` with snapE=0000, `actual_takeE`=0 → GHR=0000, even with `branchD`=1 in the same cycle.
- **Chooser:** with MODE=3, drive alternating T/N/T/N on one PC until gshare is correct and bimodal wrong. Required: CHT steps toward 11 only on disagreeing retirements and ends at 11; agreeing retirements leave it unchanged.
- **Flush/stall:**
  - `stallD`=1 holds `predictD`.
  - `flushM` on a branch in M → no table update and no stat increment.
  - `stat_miss_cnt` counts exactly the injected mispredicts (e.g. 5 of 20).
- **Wrap:** preload `stat_branch_cnt`=0xFFFFFFFF by force, then retire 1 branch → 0x00000000.
